// File: rtl/cpu_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between the pipeline (A) and long-latency units (B).
// Optional stall statistics outputs are enabled by defining CPU_WB_ARBITER_STATS_EN.
module cpu_wb_arbiter #(
   parameter int TAG_WIDTH    = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_a_valid,
   output logic                 o_a_ready,
   input  logic [4:0]           i_a_rd,
   input  logic [31:0]          i_a_data,
   input  logic                 i_b_valid,
   output logic                 o_b_ready,
   input  logic [4:0]           i_b_rd,
   input  logic [31:0]          i_b_data,
   output logic                 o_wr_valid,
   output logic [4:0]           o_wr_rd,
   output logic [31:0]          o_wr_data,
   output logic [TAG_WIDTH-1:0] o_wr_tag
`ifdef CPU_WB_ARBITER_STATS_EN
   ,
   output logic [15:0]          o_stat_a_stalls,
   output logic [15:0]          o_stat_b_stalls
`endif
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_A,
      GRANT_B
   } grant_e;

   grant_e grant;

   logic                 wr_valid_q, wr_valid_d;
   logic [4:0]           wr_rd_q, wr_rd_d;
   logic [31:0]          wr_data_q, wr_data_d;
   logic [TAG_WIDTH-1:0] wr_tag_q, wr_tag_d;
   logic [7:0]           starve_cnt_q, starve_cnt_d;
   logic                 force_b_q, force_b_d;

   logic [4:0]  sel_rd;
   logic [31:0] sel_data;
   logic        write_en;
   logic        b_refused;

   // Readies are forced low while reset is asserted so nothing is accepted during reset.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant = GRANT_NONE;
      if (!i_reset_n)
         grant = GRANT_NONE;
      else if (force_b_q && i_b_valid)
         grant = GRANT_B;
      else if (i_a_valid)
         grant = GRANT_A;
      else if (i_b_valid)
         grant = GRANT_B;
   end

   assign o_a_ready = (grant == GRANT_A);
   assign o_b_ready = (grant == GRANT_B);

   always_comb begin
      sel_rd       = i_a_rd;
      sel_data     = i_a_data;
      wr_valid_d   = 1'b0;
      wr_rd_d      = wr_rd_q;
      wr_data_d    = wr_data_q;
      wr_tag_d     = wr_tag_q;
      starve_cnt_d = 8'd0;
      force_b_d    = 1'b0;

      if (grant == GRANT_B) begin
         sel_rd   = i_b_rd;
         sel_data = i_b_data;
      end

      // Writes to x0 are accepted but discarded: no strobe, no tag advance.
      write_en = (grant != GRANT_NONE) && (sel_rd != 5'd0);
      if (write_en) begin
         wr_valid_d = 1'b1;
         wr_rd_d    = sel_rd;
         wr_data_d  = sel_data;
         wr_tag_d   = wr_tag_q + TAG_WIDTH'(1);
      end

      // Force is raised on the same edge the refusal count reaches the limit.
      b_refused = i_b_valid && !o_b_ready;
      if (b_refused) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
         force_b_d    = (starve_cnt_d >= LIMIT);
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_valid_q   <= 1'b0;
         wr_rd_q      <= 5'd0;
         wr_data_q    <= 32'd0;
         wr_tag_q     <= '0;
         starve_cnt_q <= 8'd0;
         force_b_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         wr_valid_q   <= wr_valid_d;
         wr_rd_q      <= wr_rd_d;
         wr_data_q    <= wr_data_d;
         wr_tag_q     <= wr_tag_d;
         starve_cnt_q <= starve_cnt_d;
         force_b_q    <= force_b_d;
      end
   end

   assign o_wr_valid = wr_valid_q;
   assign o_wr_rd    = wr_rd_q;
   assign o_wr_data  = wr_data_q;
   assign o_wr_tag   = wr_tag_q;

`ifdef CPU_WB_ARBITER_STATS_EN
   logic [15:0] stat_a_q, stat_a_d;
   logic [15:0] stat_b_q, stat_b_d;

   // Saturating counts of cycles each port waited while valid.
   always_comb begin
      stat_a_d = stat_a_q;
      stat_b_d = stat_b_q;
      if (i_a_valid && !o_a_ready && (stat_a_q != 16'hFFFF))
         stat_a_d = stat_a_q + 16'd1;
      if (i_b_valid && !o_b_ready && (stat_b_q != 16'hFFFF))
         stat_b_d = stat_b_q + 16'd1;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         stat_a_q <= 16'd0;
         stat_b_q <= 16'd0;
      end else begin
         stat_a_q <= stat_a_d;
         stat_b_q <= stat_b_d;
      end
   end

   assign o_stat_a_stalls = stat_a_q;
   assign o_stat_b_stalls = stat_b_q;
`endif

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Self-checking bench for cpu_wb_arbiter: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_cpu_wb_arbiter;

   localparam int TAG_WIDTH    = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int TAG_MOD      = 1 << TAG_WIDTH;

   logic        clk;
   logic        rst_n;
   logic        a_valid, b_valid;
   logic [4:0]  a_rd, b_rd;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic        wr_valid;
   logic [4:0]  wr_rd;
   logic [31:0] wr_data;
   logic [TAG_WIDTH-1:0] wr_tag;
`ifdef CPU_WB_ARBITER_STATS_EN
   logic [15:0] stat_a, stat_b;
`endif

   int n_checks = 0;
   int n_errors = 0;

   cpu_wb_arbiter #(
      .TAG_WIDTH   (TAG_WIDTH),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .i_a_valid (a_valid),
      .o_a_ready (a_ready),
      .i_a_rd    (a_rd),
      .i_a_data  (a_data),
      .i_b_valid (b_valid),
      .o_b_ready (b_ready),
      .i_b_rd    (b_rd),
      .i_b_data  (b_data),
      .o_wr_valid(wr_valid),
      .o_wr_rd   (wr_rd),
      .o_wr_data (wr_data),
      .o_wr_tag  (wr_tag)
`ifdef CPU_WB_ARBITER_STATS_EN
      ,
      .o_stat_a_stalls(stat_a),
      .o_stat_b_stalls(stat_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: B's consecutive refused-while-valid cycles, plus the write the register file should see.
   int          m_wait;
   int          m_tag;
   logic        m_wr_valid;
   logic [4:0]  m_wr_rd;
   logic [31:0] m_wr_data;

   function automatic logic exp_b_rdy();
      return rst_n && b_valid && (m_wait >= STARVE_LIMIT || !a_valid);
   endfunction

   function automatic logic exp_a_rdy();
      return rst_n && a_valid && !(b_valid && m_wait >= STARVE_LIMIT);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wait     <= 0;
         m_tag      <= 0;
         m_wr_valid <= 1'b0;
         m_wr_rd    <= 5'd0;
         m_wr_data  <= 32'd0;
      end else begin
         m_wait     <= (b_valid && !exp_b_rdy()) ? m_wait + 1 : 0;
         m_wr_valid <= 1'b0;
         if (exp_a_rdy() && a_rd != 5'd0) begin
            m_wr_valid <= 1'b1;
            m_wr_rd    <= a_rd;
            m_wr_data  <= a_data;
            m_tag      <= (m_tag + 1) % TAG_MOD;
         end else if (exp_b_rdy() && b_rd != 5'd0) begin
            m_wr_valid <= 1'b1;
            m_wr_rd    <= b_rd;
            m_wr_data  <= b_data;
            m_tag      <= (m_tag + 1) % TAG_MOD;
         end
      end
   end

   always @(negedge clk) begin
      check("a_ready", 32'(a_ready), 32'(exp_a_rdy()));
      check("b_ready", 32'(b_ready), 32'(exp_b_rdy()));
      check("wr_valid", 32'(wr_valid), 32'(m_wr_valid));
      check("wr_rd", 32'(wr_rd), 32'(m_wr_rd));
      check("wr_data", wr_data, m_wr_data);
      check("wr_tag", 32'(wr_tag), 32'(m_tag));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int refused;
      logic found;
      logic a_acc, b_acc;

      a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
      b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
      rst_n   = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_wr_tag", 32'(wr_tag), 32'd0);
      rst_n = 1'b1;

      // Single A write
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
      #1 check("single_a_ready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      check("single_wr_valid", 32'(wr_valid), 32'd1);
      check("single_wr_rd", 32'(wr_rd), 32'd5);
      check("single_wr_data", wr_data, 32'hDEADBEEF);
      check("single_wr_tag", 32'(wr_tag), 32'd1);
      tick();
      check("single_pulse_end", 32'(wr_valid), 32'd0);

      // Simultaneous A and B
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'd1;
      b_valid = 1'b1; b_rd = 5'd4; b_data = 32'd2;
      #1;
      check("sim_a_ready", 32'(a_ready), 32'd1);
      check("sim_b_refused", 32'(b_ready), 32'd0);
      tick();
      a_valid = 1'b0;
      #1;
      check("sim_b_ready", 32'(b_ready), 32'd1);
      check("sim_wr_rd_a", 32'(wr_rd), 32'd3);
      check("sim_tag_a", 32'(wr_tag), 32'd2);
      tick();
      b_valid = 1'b0;
      check("sim_wr_rd_b", 32'(wr_rd), 32'd4);
      check("sim_wr_data_b", wr_data, 32'd2);
      check("sim_tag_b", 32'(wr_tag), 32'd3);
      tick();

      // Starvation under continuous A traffic
      a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h0000_0077;
      b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h0000_0099;
      refused = 0;
      found   = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (b_ready) begin
            check("starve_a_blocked", 32'(a_ready), 32'd0);
            found = 1'b1;
            break;
         end
         refused++;
         tick();
      end
      check("starve_found", 32'(found), 32'd1);
      check("starve_wait", 32'(refused), 32'(STARVE_LIMIT));
      tick();
      b_valid = 1'b0;
      #1 check("starve_a_resumes", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      tick();
      check("starve_tag", 32'(wr_tag), 32'd13);

      // rd == 0 on B is accepted and discarded
      b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFFFFFF;
      #1 check("rd0_b_ready", 32'(b_ready), 32'd1);
      tick();
      b_valid = 1'b0;
      check("rd0_no_pulse", 32'(wr_valid), 32'd0);
      check("rd0_tag_held", 32'(wr_tag), 32'd13);
      check("rd0_rd_held", 32'(wr_rd), 32'd7);

      // Async reset mid-burst
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1234_5678;
      repeat (3) tick();
      #1 rst_n = 1'b0;
      #1;
      check("arst_wr_valid", 32'(wr_valid), 32'd0);
      check("arst_wr_rd", 32'(wr_rd), 32'd0);
      check("arst_wr_data", wr_data, 32'd0);
      check("arst_wr_tag", 32'(wr_tag), 32'd0);
      check("arst_a_ready", 32'(a_ready), 32'd0);
      a_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Tag wrap: 16 writes to rd=1
      a_valid = 1'b1; a_rd = 5'd1;
      for (int i = 0; i < 16; i++) begin
         a_data = 32'(i);
         tick();
         check("wrap_wr_valid", 32'(wr_valid), 32'd1);
         check("wrap_tag", 32'(wr_tag), 32'((i + 1) % TAG_MOD));
      end
      a_valid = 1'b0;
      tick();

      // Randomized traffic; requesters hold their request until accepted
      a_acc = 1'b0;
      b_acc = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!a_valid || a_acc) begin
            a_valid = ($urandom_range(0, 9) < 7);
            a_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a_data  = $urandom;
         end
         if (!b_valid || b_acc) begin
            b_valid = ($urandom_range(0, 9) < 5);
            b_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            b_data  = $urandom;
         end
         #1;
         a_acc = exp_a_rdy();
         b_acc = exp_b_rdy();
         tick();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
